alu_ctrl_decode: RTL and testbench
==================================

Name: alu_ctrl_decode

Overview:
- ID-stage producer for the 4-bit ALU control code consumed by the EX-stage ALU.
- Decodes ARM-32 data-processing instructions into aluctrl, operand selects, an immediate and register fields.
- Registers the result into a one-entry ID/EX pipeline register with valid/ready handshake, flush, and a saturating illegal-instruction counter.
- Sits between IF/ID and the EX stage.

Parameters:
- DATA_WIDTH, 32, width of the instruction word and of the imm output.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  instr is valid this cycle
- in_ready  output  1  decoder can accept instr this cycle
- instr  input  DATA_WIDTH  ARM-32 instruction word
- flush  input  1  synchronous squash of the registered entry and of any input this cycle
- out_valid  output  1  registered decode is valid
- out_ready  input  1  EX stage consumes the entry this cycle
- aluctrl  output  4  ALU code: NOP 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, SHIFTLV 1000, SHIFTRV 1001
- a_sel  output  2  operand A source: 00 Rn, 01 zero, 10 Rm
- b_sel  output  1  operand B source: 0 Rm, 1 imm
- imm  output  DATA_WIDTH  zero-extended immediate or shift amount
- rd, rn, rm  output  4 each  register indices
- cond  output  4  instr[31:28], passed through
- reg_write  output  1  result written to rd
- set_flags  output  1  instr S bit, or forced to 1 for CMP
- is_dp  output  1  instr[27:26] == 00
- illegal  output  1  unsupported data-processing form
- illegal_cnt  output  CNT_W  saturating count of accepted illegal entries

Behaviour:
- Reset, asynchronous: out_valid=0, all decode outputs 0, aluctrl=0000, illegal_cnt=0.
- in_ready = !out_valid || out_ready. Combinational; it does not depend on in_valid.
- Accept condition: in_valid && in_ready && !flush. On accept, decode outputs load at the next edge, out_valid=1. Latency is 1 cycle.
- No accept and out_ready=1: out_valid clears at the next edge.
- No accept and out_ready=0: the entry holds stable, with every output unchanged.
- flush=1: out_valid=0 at the next edge and the input is discarded. Flush has priority over accept and hold. The counter does not increment.
- Fields: rn=instr[19:16], rd=instr[15:12], rm=instr[3:0], I=instr[25], op=instr[24:21], S=instr[20].
- I=1: imm = ROR(zero-extended instr[7:0], 2*instr[11:8]); b_sel=1.
- I=0 and op is not MOV: instr[11:4] must be 0, otherwise illegal. b_sel=0.
- Opcode mapping; a_sel=Rn unless noted, reg_write=1 unless noted:
  - AND 0000 -> 0011
  - SUB 0010 -> 0010
  - ADD 0100 -> 0001
  - ORR 1100 -> 0100
  - CMP 1010 -> 0010, reg_write=0, set_flags=1
- MOV 1101 with I=1: OR, a_sel=zero, b_sel=imm.
- MOV 1101 with I=0, per instr[11:4] (shamt=instr[11:7], type=instr[6:5], instr[4]=0 required):
  - instr[11:4]==0: OR, a_sel=zero, b_sel=Rm.
  - type 00 (LSL), shamt!=0: SHIFTLV, a_sel=Rm, b_sel=imm, imm=shamt.
  - type 01 (LSR): SHIFTRV, same selects; shamt=0 encodes 32, so imm=32.
  - type 10/11 or instr[4]=1: illegal.
- Other opcodes on a DP instruction: illegal.
- illegal=1 forces aluctrl=0000, reg_write=0, set_flags=0. Other fields are still loaded.
- is_dp=0: aluctrl=0000, reg_write=0, set_flags=0, illegal=0. Fields are still loaded.
- illegal_cnt increments by 1 on each accepted illegal instruction. It saturates at all-ones and does not wrap.

Decomposition:
- Shared package alu_pkg holds:
  - ALU code localparams, shared with the ALU.
  - ARM opcode constants.
  - a_sel/b_sel encodings.
- One combinational sub-module, dp_field_decode: instr in, next-decode bundle out.
- This module holds the handshake register and the counter.

Test Plan:
- ADD r1,r2,r3 = 0xE0821003, out_ready=1 -> next cycle out_valid=1, aluctrl=0001, rd=1, rn=2, rm=3, a_sel=00, b_sel=0, reg_write=1.
- SUB r0,r0,#0x3F0 = 0xE2400E3F -> aluctrl=0010, b_sel=1, imm=0x000003F0.
- MOV r4,r5,LSR #3 = 0xE1A041A5 -> aluctrl=1001, a_sel=10, rm=5, b_sel=1, imm=3, rd=4.
- CMP r1,r2 = 0xE1510002 -> aluctrl=0010, reg_write=0, set_flags=1.
- EOR r1,r2,r3 = 0xE0221003 -> illegal=1, aluctrl=0000, reg_write=0, illegal_cnt=1. Preloading the counter to 0xFFFF and repeating leaves it at 0xFFFF.
- Backpressure and flush:
  - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout.
  - flush asserted together with in_valid -> out_valid=0 next cycle and counter unchanged.
  - reset asserted mid-hold -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, ARM data-processing opcodes, operand-select encodings
// and the decoded-instruction bundle passed from field decode to the ID/EX register.
package alu_pkg;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b1000;
    localparam logic [3:0] ALU_SHR = 4'b1001;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;

    localparam logic [1:0] ASEL_RN   = 2'b00;
    localparam logic [1:0] ASEL_ZERO = 2'b01;
    localparam logic [1:0] ASEL_RM   = 2'b10;
    localparam logic       BSEL_RM   = 1'b0;
    localparam logic       BSEL_IMM  = 1'b1;

    typedef struct packed {
        logic [3:0] aluctrl;
        logic [1:0] a_sel;
        logic       b_sel;
        logic [3:0] rd;
        logic [3:0] rn;
        logic [3:0] rm;
        logic [3:0] cond;
        logic       reg_write;
        logic       set_flags;
        logic       is_dp;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/dp_field_decode.sv
// Combinational decode of one ARM-32 data-processing word into the dec_t bundle and immediate.
// Zero latency, no state; backpressure is handled entirely by the enclosing register stage.
module dp_field_decode
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] instr,
    output dec_t                  dec,
    output logic [DATA_WIDTH-1:0] imm
);

    logic                    i_bit;
    logic [3:0]              op;
    logic [7:0]              shf;
    logic [4:0]              shamt;
    logic [2*DATA_WIDTH-1:0] rot_dbl;
    logic [DATA_WIDTH-1:0]   imm8;
    logic                    legal;
    logic [3:0]              alu;
    logic                    wr;
    logic                    sf;

    assign i_bit = instr[25];
    assign op    = instr[24:21];
    assign shf   = instr[11:4];
    assign shamt = instr[11:7];
    assign imm8  = {{(DATA_WIDTH-8){1'b0}}, instr[7:0]};
    // Rotating a doubled copy right leaves the ROR result in the low half.
    assign rot_dbl = {imm8, imm8} >> {instr[11:8], 1'b0};

    always_comb begin
        dec       = '0;
        dec.rd    = instr[15:12];
        dec.rn    = instr[19:16];
        dec.rm    = instr[3:0];
        dec.cond  = instr[31:28];
        dec.is_dp = (instr[27:26] == 2'b00);
        dec.a_sel = ASEL_RN;
        dec.b_sel = i_bit ? BSEL_IMM : BSEL_RM;
        imm       = i_bit ? rot_dbl[DATA_WIDTH-1:0] : '0;
        legal     = 1'b1;
        alu       = ALU_NOP;
        wr        = 1'b1;
        sf        = instr[20];

        if (!i_bit && op != OP_MOV && shf != 8'd0) legal = 1'b0;

        case (op)
            OP_AND: alu = ALU_AND;
            OP_SUB: alu = ALU_SUB;
            OP_ADD: alu = ALU_ADD;
            OP_ORR: alu = ALU_OR;
            OP_CMP: begin
                alu = ALU_SUB;
                wr  = 1'b0;
                sf  = 1'b1;
            end
            OP_MOV: begin
                alu = ALU_OR;
                if (i_bit || shf == 8'd0) begin
                    dec.a_sel = ASEL_ZERO;
                end else if (!instr[4] && instr[6:5] == 2'b00) begin
                    alu       = ALU_SHL;
                    dec.a_sel = ASEL_RM;
                    dec.b_sel = BSEL_IMM;
                    imm       = {{(DATA_WIDTH-5){1'b0}}, shamt};
                end else if (!instr[4] && instr[6:5] == 2'b01) begin
                    // LSR #0 is the architectural encoding of LSR #32.
                    alu       = ALU_SHR;
                    dec.a_sel = ASEL_RM;
                    dec.b_sel = BSEL_IMM;
                    imm       = (shamt == 5'd0) ? DATA_WIDTH'(32)
                                                : {{(DATA_WIDTH-5){1'b0}}, shamt};
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        if (!dec.is_dp) begin
            dec.aluctrl   = ALU_NOP;
            dec.reg_write = 1'b0;
            dec.set_flags = 1'b0;
            dec.illegal   = 1'b0;
        end else if (!legal) begin
            dec.aluctrl   = ALU_NOP;
            dec.reg_write = 1'b0;
            dec.set_flags = 1'b0;
            dec.illegal   = 1'b1;
        end else begin
            dec.aluctrl   = alu;
            dec.reg_write = wr;
            dec.set_flags = sf;
            dec.illegal   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_ctrl_decode.sv
// ID-stage ALU control decode into a one-entry ID/EX register; 1-cycle latency, flush has priority.
// in_ready = !out_valid || out_ready; without acceptance and out_ready=0 the entry holds unchanged.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            aluctrl,
    output logic [1:0]            a_sel,
    output logic                  b_sel,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [3:0]            rd,
    output logic [3:0]            rn,
    output logic [3:0]            rm,
    output logic [3:0]            cond,
    output logic                  reg_write,
    output logic                  set_flags,
    output logic                  is_dp,
    output logic                  illegal,
    output logic [CNT_W-1:0]      illegal_cnt
);

    dec_t                  dec_nxt;
    dec_t                  dec_q;
    logic [DATA_WIDTH-1:0] imm_nxt;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  accept;

    dp_field_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .instr (instr),
        .dec   (dec_nxt),
        .imm   (imm_nxt)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            dec_q       <= '0;
            imm_q       <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            dec_q     <= dec_nxt;
            imm_q     <= imm_nxt;
            if (dec_nxt.illegal && illegal_cnt != {CNT_W{1'b1}})
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign aluctrl   = dec_q.aluctrl;
    assign a_sel     = dec_q.a_sel;
    assign b_sel     = dec_q.b_sel;
    assign imm       = imm_q;
    assign rd        = dec_q.rd;
    assign rn        = dec_q.rn;
    assign rm        = dec_q.rm;
    assign cond      = dec_q.cond;
    assign reg_write = dec_q.reg_write;
    assign set_flags = dec_q.set_flags;
    assign is_dp     = dec_q.is_dp;
    assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Bench for alu_ctrl_decode: vector table, handshake/flush/reset sequences, randomized scoreboard.
module tb_alu_ctrl_decode;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic        rw;
        logic        sf;
        logic        ill;
        logic        dp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = 32'd0;

    logic        in_ready, out_valid, b_sel, reg_write, set_flags, is_dp, illegal;
    logic [3:0]  aluctrl, rd, rn, rm, cond;
    logic [1:0]  a_sel;
    logic [31:0] imm;
    logic [15:0] illegal_cnt;

    logic        s_in_ready, s_out_valid, s_b_sel, s_reg_write, s_set_flags, s_is_dp, s_illegal;
    logic [3:0]  s_aluctrl, s_rd, s_rn, s_rm, s_cond;
    logic [1:0]  s_a_sel;
    logic [31:0] s_imm;
    logic [2:0]  s_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_ctrl_decode dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .aluctrl(aluctrl),
        .a_sel(a_sel), .b_sel(b_sel), .imm(imm), .rd(rd), .rn(rn), .rm(rm), .cond(cond),
        .reg_write(reg_write), .set_flags(set_flags), .is_dp(is_dp), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    alu_ctrl_decode #(.DATA_WIDTH(32), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .instr(instr),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .aluctrl(s_aluctrl),
        .a_sel(s_a_sel), .b_sel(s_b_sel), .imm(s_imm), .rd(s_rd), .rn(s_rn), .rm(s_rm),
        .cond(s_cond), .reg_write(s_reg_write), .set_flags(s_set_flags), .is_dp(s_is_dp),
        .illegal(s_illegal), .illegal_cnt(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t ref_decode(input logic [31:0] w);
        vec_t        e;
        logic [31:0] v;
        logic        ok;
        int          sh;
        v = {24'd0, w[7:0]};
        for (int k = 0; k < 2 * int'(w[11:8]); k++) v = {v[0], v[31:1]};
        sh = int'(w[11:7]);
        e.instr = w;
        e.dp    = (w[27:26] == 2'b00);
        e.a_sel = 2'b00;
        e.b_sel = w[25];
        e.imm   = w[25] ? v : 32'd0;
        e.rw    = 1'b1;
        e.sf    = w[20];
        e.alu   = 4'd0;
        ok      = 1'b1;
        if (!w[25] && w[24:21] != 4'd13 && w[11:4] != 8'd0) ok = 1'b0;
        if (w[24:21] == 4'd0)       e.alu = 4'd3;
        else if (w[24:21] == 4'd2)  e.alu = 4'd2;
        else if (w[24:21] == 4'd4)  e.alu = 4'd1;
        else if (w[24:21] == 4'd12) e.alu = 4'd4;
        else if (w[24:21] == 4'd10) begin e.alu = 4'd2; e.rw = 1'b0; e.sf = 1'b1; end
        else if (w[24:21] == 4'd13) begin
            e.alu = 4'd4;
            if (w[25] || w[11:4] == 8'd0) e.a_sel = 2'b01;
            else if (w[4] || w[6]) ok = 1'b0;
            else begin
                e.a_sel = 2'b10;
                e.b_sel = 1'b1;
                e.alu   = w[5] ? 4'd9 : 4'd8;
                e.imm   = (w[5] && sh == 0) ? 32'd32 : 32'(sh);
            end
        end else ok = 1'b0;
        e.ill = e.dp && !ok;
        if (!e.dp || !ok) begin e.alu = 4'd0; e.rw = 1'b0; e.sf = 1'b0; end
        return e;
    endfunction

    task automatic chk_entry(input string tag, input vec_t e);
        chk({tag, ".aluctrl"}, 32'(aluctrl), 32'(e.alu));
        chk({tag, ".a_sel"}, 32'(a_sel), 32'(e.a_sel));
        chk({tag, ".b_sel"}, 32'(b_sel), 32'(e.b_sel));
        chk({tag, ".imm"}, imm, e.imm);
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(e.rw));
        chk({tag, ".set_flags"}, 32'(set_flags), 32'(e.sf));
        chk({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
        chk({tag, ".is_dp"}, 32'(is_dp), 32'(e.dp));
        chk({tag, ".regs"}, {16'd0, cond, rn, rd, rm},
            {16'd0, e.instr[31:28], e.instr[19:16], e.instr[15:12], e.instr[3:0]});
        chk({tag, ".s_aluctrl"}, 32'(s_aluctrl), 32'(e.alu));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[$];
    vec_t        cur;
    vec_t        held;
    int          n_ill;
    logic        m_valid;
    vec_t        m_ent;
    int          m_cnt;
    int          m_scnt;
    logic [31:0] w;
    logic        acc;

    initial begin
        //      instr         alu    a_sel  b   imm           rw    sf    ill   dp
        tbl.push_back('{32'hE0821003, 4'h1, 2'b00, 0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{32'hE2400E3F, 4'h2, 2'b00, 1, 32'h000003F0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{32'hE1A041A5, 4'h9, 2'b10, 1, 32'h3,        1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{32'hE1510002, 4'h2, 2'b00, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{32'hE0221003, 4'h0, 2'b00, 0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{32'hE39210FF, 4'h4, 2'b00, 1, 32'h000000FF, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{32'hE3A004FF, 4'h4, 2'b01, 1, 32'hFF000000, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{32'hE1A02003, 4'h4, 2'b01, 0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{32'hE1A02203, 4'h8, 2'b10, 1, 32'h4,        1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{32'hE1A02023, 4'h9, 2'b10, 1, 32'd32,       1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{32'hE1A020C3, 4'h0, 2'b00, 0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{32'hE1A02313, 4'h0, 2'b00, 0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{32'hE0821083, 4'h0, 2'b00, 0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{32'hE5912004, 4'h0, 2'b00, 0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{32'hE2911005, 4'h1, 2'b00, 1, 32'h5,        1'b1, 1'b1, 1'b0, 1'b1});

        #12;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.aluctrl", 32'(aluctrl), 32'd0);
        chk("reset.imm", imm, 32'd0);
        chk("reset.cnt", 32'(illegal_cnt), 32'd0);
        reset = 1'b0;
        tick();
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // Vector table, one instruction per cycle with the consumer always ready.
        n_ill = 0;
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            in_valid = 1'b1;
            instr = tbl[i].instr;
            tick();
            if (tbl[i].ill) n_ill++;
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'd1);
            chk_entry($sformatf("vec%0d", i), tbl[i]);
            cur = ref_decode(tbl[i].instr);
            chk($sformatf("vec%0d.model", i), {cur.alu, cur.a_sel, 1'b0, cur.b_sel, cur.imm[23:0]},
                {aluctrl, a_sel, 1'b0, b_sel, imm[23:0]});
            chk($sformatf("vec%0d.cnt", i), 32'(illegal_cnt), 32'(n_ill));
        end
        in_valid = 1'b0;
        tick();
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // Counter saturation on the narrow instance.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            instr = 32'hE0221003;
            tick();
            n_ill++;
            chk("sat.cnt", 32'(illegal_cnt), 32'(n_ill));
            chk("sat.s_cnt", 32'(s_cnt), 32'(n_ill > 7 ? 7 : n_ill));
        end

        // Backpressure: the held ADD must not be replaced by the waiting SUB.
        instr = 32'hE0821003;
        tick();
        out_ready = 1'b0;
        instr = 32'hE2400E3F;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk_entry("bp", tbl[0]);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_rdy", 32'(in_ready), 32'd1);
        tick();
        chk_entry("bp.next", tbl[1]);

        // Flush with a concurrent illegal input: squashed, counter unchanged.
        instr = 32'hE0221003;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.cnt", 32'(illegal_cnt), 32'(n_ill));

        // Randomized traffic against the scoreboard model.
        m_valid = 1'b0;
        m_ent = tbl[0];
        m_cnt = n_ill;
        m_scnt = 7;
        for (int c = 0; c < 600; c++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[27:26] = 2'b00;
            case ($urandom_range(0, 7))
                0: w[24:21] = 4'd0;
                1: w[24:21] = 4'd2;
                2: w[24:21] = 4'd4;
                3: w[24:21] = 4'd12;
                4: w[24:21] = 4'd10;
                5, 6: w[24:21] = 4'd13;
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) w[11:4] = 8'd0;
            else if ($urandom_range(0, 1) == 0) w[6:4] = 3'($urandom_range(0, 1) << 1);
            instr = w;
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 15) == 0);
            #1;
            chk("rnd.in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            acc = in_valid && (!m_valid || out_ready) && !flush;
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1;
                m_ent = ref_decode(w);
                if (m_ent.ill) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_scnt < 7) m_scnt++;
                end
            end else if (out_ready) m_valid = 1'b0;
            tick();
            chk("rnd.out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) chk_entry("rnd", m_ent);
            chk("rnd.cnt", 32'(illegal_cnt), 32'(m_cnt));
            chk("rnd.s_cnt", 32'(s_cnt), 32'(m_scnt));
        end

        // Asynchronous reset while an entry is being held.
        flush = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        instr = 32'hE0821003;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("hold.out_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.aluctrl", 32'(aluctrl), 32'd0);
        chk("arst.cnt", 32'(illegal_cnt), 32'd0);
        chk("arst.s_cnt", 32'(s_cnt), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
